// File: rtl/mc_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_unit_if
// Description : Decoded-instruction inputs and datapath control outputs of
//               the multicycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_control_unit_if;
    logic [5:0] OPCODE;
    logic [5:0] FUNCT;
    logic       ZERO;
    logic       OVERFLOW;
    logic       mult_end;

    logic       PC_w;
    logic       EPC_w;
    logic       MEM_w;
    logic       IR_w;
    logic       ALUOut_w;
    logic       RB_w;
    logic       AB_w;
    logic       MEM_DATA_REG_w;
    logic       mult_control;

    logic [1:0] M_PC;
    logic [1:0] M_MEM;
    logic [1:0] M_ALUSrcA;
    logic [1:0] M_ALUSrcB;
    logic [1:0] M_WREG;
    logic [1:0] M_WDATA;
    logic [1:0] M_EXC;
    logic [3:0] ALUOp;
    logic [1:0] LS_control;
    logic [1:0] SS_control;
    logic [5:0] state_dbg;

    modport master (
        input  OPCODE, FUNCT, ZERO, OVERFLOW, mult_end,
        output PC_w, EPC_w, MEM_w, IR_w, ALUOut_w, RB_w, AB_w, MEM_DATA_REG_w,
               mult_control, M_PC, M_MEM, M_ALUSrcA, M_ALUSrcB, M_WREG,
               M_WDATA, M_EXC, ALUOp, LS_control, SS_control, state_dbg
    );

    modport slave (
        output OPCODE, FUNCT, ZERO, OVERFLOW, mult_end,
        input  PC_w, EPC_w, MEM_w, IR_w, ALUOut_w, RB_w, AB_w, MEM_DATA_REG_w,
               mult_control, M_PC, M_MEM, M_ALUSrcA, M_ALUSrcB, M_WREG,
               M_WDATA, M_EXC, ALUOp, LS_control, SS_control, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_unit
// Description : Multicycle MIPS-subset control FSM: fetch, decode, execute,
//               memory, writeback and the exception sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_unit (
    input  wire logic          clk,
    input  wire logic          reset,
    mc_control_unit_if.master  bus
);

    localparam logic [5:0] c_st_reset = 6'd0;
    localparam logic [5:0] c_st_f0    = 6'd1;
    localparam logic [5:0] c_st_f1    = 6'd2;
    localparam logic [5:0] c_st_f2    = 6'd3;
    localparam logic [5:0] c_st_d     = 6'd4;
    localparam logic [5:0] c_st_ex    = 6'd5;
    localparam logic [5:0] c_st_wb    = 6'd6;
    localparam logic [5:0] c_st_ac    = 6'd7;
    localparam logic [5:0] c_st_m0    = 6'd8;
    localparam logic [5:0] c_st_m1    = 6'd9;
    localparam logic [5:0] c_st_m2    = 6'd10;
    localparam logic [5:0] c_st_lwb   = 6'd11;
    localparam logic [5:0] c_st_sw    = 6'd12;
    localparam logic [5:0] c_st_br    = 6'd13;
    localparam logic [5:0] c_st_j     = 6'd14;
    localparam logic [5:0] c_st_jal0  = 6'd15;
    localparam logic [5:0] c_st_jal1  = 6'd16;
    localparam logic [5:0] c_st_jr    = 6'd17;
    localparam logic [5:0] c_st_ms    = 6'd18;
    localparam logic [5:0] c_st_mw    = 6'd19;
    localparam logic [5:0] c_st_exc0  = 6'd20;
    localparam logic [5:0] c_st_exc1  = 6'd21;
    localparam logic [5:0] c_st_exc2  = 6'd22;
    localparam logic [5:0] c_st_exc3  = 6'd23;

    localparam logic [5:0] c_opc_rtype = 6'h00;
    localparam logic [5:0] c_opc_j     = 6'h02;
    localparam logic [5:0] c_opc_jal   = 6'h03;
    localparam logic [5:0] c_opc_beq   = 6'h04;
    localparam logic [5:0] c_opc_bne   = 6'h05;
    localparam logic [5:0] c_opc_addi  = 6'h08;
    localparam logic [5:0] c_opc_lw    = 6'h23;
    localparam logic [5:0] c_opc_sw    = 6'h2B;

    localparam logic [5:0] c_fn_jr     = 6'h08;
    localparam logic [5:0] c_fn_mfhi   = 6'h10;
    localparam logic [5:0] c_fn_mflo   = 6'h12;
    localparam logic [5:0] c_fn_mult   = 6'h18;
    localparam logic [5:0] c_fn_add    = 6'h20;
    localparam logic [5:0] c_fn_sub    = 6'h22;
    localparam logic [5:0] c_fn_and    = 6'h24;

    localparam logic [2:0] c_op_add    = 3'd0;
    localparam logic [2:0] c_op_sub    = 3'd1;
    localparam logic [2:0] c_op_and    = 3'd2;
    localparam logic [2:0] c_op_addi   = 3'd3;
    localparam logic [2:0] c_op_mfhi   = 3'd4;
    localparam logic [2:0] c_op_mflo   = 3'd5;
    localparam logic [2:0] c_op_lw     = 3'd6;
    localparam logic [2:0] c_op_sw     = 3'd7;

    localparam logic [3:0] c_alu_pass  = 4'b0000;
    localparam logic [3:0] c_alu_add   = 4'b0001;
    localparam logic [3:0] c_alu_sub   = 4'b0010;
    localparam logic [3:0] c_alu_and   = 4'b0011;

    localparam logic [1:0] c_exc_opcode   = 2'd0;
    localparam logic [1:0] c_exc_overflow = 2'd1;

    logic [5:0] r_state;
    logic [2:0] r_op;
    logic [1:0] r_exc;
    logic [5:0] w_disp_state;
    logic [2:0] w_disp_op;

    // Decode-stage dispatch; anything unrecognised falls through to EXC0.
    always_comb begin
        w_disp_state = c_st_exc0;
        w_disp_op    = c_op_add;
        case (bus.OPCODE)
            c_opc_rtype:
                case (bus.FUNCT)
                    c_fn_add:  begin w_disp_state = c_st_ex; w_disp_op = c_op_add;  end
                    c_fn_sub:  begin w_disp_state = c_st_ex; w_disp_op = c_op_sub;  end
                    c_fn_and:  begin w_disp_state = c_st_ex; w_disp_op = c_op_and;  end
                    c_fn_jr:   w_disp_state = c_st_jr;
                    c_fn_mult: w_disp_state = c_st_ms;
                    c_fn_mfhi: begin w_disp_state = c_st_wb; w_disp_op = c_op_mfhi; end
                    c_fn_mflo: begin w_disp_state = c_st_wb; w_disp_op = c_op_mflo; end
                    default:   ;
                endcase
            c_opc_addi: begin w_disp_state = c_st_ex; w_disp_op = c_op_addi; end
            c_opc_lw:   begin w_disp_state = c_st_ac; w_disp_op = c_op_lw;   end
            c_opc_sw:   begin w_disp_state = c_st_ac; w_disp_op = c_op_sw;   end
            c_opc_beq,
            c_opc_bne:  w_disp_state = c_st_br;
            c_opc_j:    w_disp_state = c_st_j;
            c_opc_jal:  w_disp_state = c_st_jal0;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_reset;
            r_op    <= c_op_add;
            r_exc   <= c_exc_opcode;
        end else begin
            case (r_state)
                c_st_reset: r_state <= c_st_f0;
                c_st_f0:    r_state <= c_st_f1;
                c_st_f1:    r_state <= c_st_f2;
                c_st_f2:    r_state <= c_st_d;
                c_st_d: begin
                    r_state <= w_disp_state;
                    r_op    <= w_disp_op;
                    r_exc   <= c_exc_opcode;
                end
                c_st_ex: begin
                    // and never overflows; add/sub/addi trap before writeback
                    if (bus.OVERFLOW && (r_op != c_op_and)) begin
                        r_state <= c_st_exc0;
                        r_exc   <= c_exc_overflow;
                    end else begin
                        r_state <= c_st_wb;
                    end
                end
                c_st_ac:    r_state <= (r_op == c_op_lw) ? c_st_m0 : c_st_sw;
                c_st_m0:    r_state <= c_st_m1;
                c_st_m1:    r_state <= c_st_m2;
                c_st_m2:    r_state <= c_st_lwb;
                c_st_jal0:  r_state <= c_st_jal1;
                c_st_ms:    r_state <= c_st_mw;
                c_st_mw:    r_state <= bus.mult_end ? c_st_f0 : c_st_mw;
                c_st_exc0:  r_state <= c_st_exc1;
                c_st_exc1:  r_state <= c_st_exc2;
                c_st_exc2:  r_state <= c_st_exc3;
                c_st_wb, c_st_lwb, c_st_sw, c_st_br, c_st_j,
                c_st_jal1, c_st_jr, c_st_exc3:
                            r_state <= c_st_f0;
                default:    r_state <= c_st_reset;
            endcase
        end
    end

    assign bus.state_dbg = r_state;

    always_comb begin
        bus.PC_w           = 1'b0;
        bus.EPC_w          = 1'b0;
        bus.MEM_w          = 1'b0;
        bus.IR_w           = 1'b0;
        bus.ALUOut_w       = 1'b0;
        bus.RB_w           = 1'b0;
        bus.AB_w           = 1'b0;
        bus.MEM_DATA_REG_w = 1'b0;
        bus.mult_control   = 1'b0;
        bus.M_PC           = 2'd0;
        bus.M_MEM          = 2'd0;
        bus.M_ALUSrcA      = 2'd0;
        bus.M_ALUSrcB      = 2'd0;
        bus.M_WREG         = 2'd0;
        bus.M_WDATA        = 2'd0;
        bus.M_EXC          = 2'd0;
        bus.ALUOp          = c_alu_pass;
        bus.LS_control     = 2'd0;
        bus.SS_control     = 2'd0;
        case (r_state)
            c_st_f2: begin
                bus.IR_w = 1'b1; bus.M_ALUSrcB = 2'd1; bus.ALUOp = c_alu_add; bus.PC_w = 1'b1;
            end
            c_st_d: begin
                bus.AB_w = 1'b1; bus.M_ALUSrcB = 2'd3; bus.ALUOp = c_alu_add; bus.ALUOut_w = 1'b1;
            end
            c_st_ex: begin
                bus.M_ALUSrcA = 2'd1;
                bus.M_ALUSrcB = (r_op == c_op_addi) ? 2'd2 : 2'd0;
                bus.ALUOut_w  = 1'b1;
                case (r_op)
                    c_op_sub: bus.ALUOp = c_alu_sub;
                    c_op_and: bus.ALUOp = c_alu_and;
                    default:  bus.ALUOp = c_alu_add;
                endcase
            end
            c_st_wb: begin
                bus.RB_w   = 1'b1;
                bus.M_WREG = (r_op == c_op_addi) ? 2'd0 : 2'd1;
                case (r_op)
                    c_op_mfhi: bus.M_WDATA = 2'd2;
                    c_op_mflo: bus.M_WDATA = 2'd3;
                    default:   bus.M_WDATA = 2'd0;
                endcase
            end
            c_st_ac: begin
                bus.M_ALUSrcA = 2'd1; bus.M_ALUSrcB = 2'd2; bus.ALUOp = c_alu_add; bus.ALUOut_w = 1'b1;
            end
            c_st_m0:  bus.M_MEM = 2'd1;
            c_st_m2:  bus.MEM_DATA_REG_w = 1'b1;
            c_st_lwb: begin
                bus.RB_w = 1'b1; bus.M_WDATA = 2'd1;
            end
            c_st_sw: begin
                bus.M_MEM = 2'd1; bus.MEM_w = 1'b1;
            end
            c_st_br: begin
                bus.M_ALUSrcA = 2'd1; bus.ALUOp = c_alu_sub; bus.M_PC = 2'd1;
                // bne is the odd opcode: take the branch when operands differ
                bus.PC_w = bus.OPCODE[0] ? ~bus.ZERO : bus.ZERO;
            end
            c_st_j: begin
                bus.M_PC = 2'd2; bus.PC_w = 1'b1;
            end
            c_st_jal0: bus.ALUOut_w = 1'b1;
            c_st_jal1: begin
                bus.RB_w = 1'b1; bus.M_WREG = 2'd2; bus.M_PC = 2'd2; bus.PC_w = 1'b1;
            end
            c_st_jr: begin
                bus.M_ALUSrcA = 2'd1; bus.PC_w = 1'b1;
            end
            c_st_ms: bus.mult_control = 1'b1;
            c_st_exc0: begin
                bus.M_ALUSrcB = 2'd1; bus.ALUOp = c_alu_sub; bus.ALUOut_w = 1'b1; bus.M_EXC = r_exc;
            end
            c_st_exc1: begin
                bus.EPC_w = 1'b1; bus.M_MEM = 2'd3; bus.M_EXC = r_exc;
            end
            c_st_exc2: begin
                bus.M_MEM = 2'd3; bus.M_EXC = r_exc;
            end
            c_st_exc3: begin
                bus.M_ALUSrcA = 2'd2; bus.PC_w = 1'b1; bus.M_EXC = r_exc;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_unit
// Description : Directed per-cycle checks of every control output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mc_control_unit_if bus ();

    mc_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {strobes[8:0], M_PC, M_MEM, SrcA, SrcB, WREG, WDATA, EXC, ALUOp, LS, SS}
    logic [30:0] obs;
    assign obs = {bus.PC_w, bus.EPC_w, bus.MEM_w, bus.IR_w, bus.ALUOut_w, bus.RB_w,
                  bus.AB_w, bus.MEM_DATA_REG_w, bus.mult_control, bus.M_PC, bus.M_MEM,
                  bus.M_ALUSrcA, bus.M_ALUSrcB, bus.M_WREG, bus.M_WDATA, bus.M_EXC,
                  bus.ALUOp, bus.LS_control, bus.SS_control};

    localparam logic [8:0] PCW = 9'h100, EPCW = 9'h080, MEMW = 9'h040, IRW = 9'h020,
                           AOW = 9'h010, RBW = 9'h008, ABW = 9'h004, MDRW = 9'h002,
                           MC = 9'h001, NONE = 9'h000;
    localparam logic [3:0] PASS = 4'b0000, ADD = 4'b0001, SUB = 4'b0010, AND = 4'b0011;
    localparam logic [3:0] Z4 = 4'b0000;

    //                                strobes      PC    MEM   SrcA  SrcB  WREG  WDATA EXC
    localparam logic [30:0] X_ZERO  = 31'd0;
    localparam logic [30:0] X_F2    = {IRW | PCW,  2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, ADD,  Z4};
    localparam logic [30:0] X_D     = {ABW | AOW,  2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, ADD,  Z4};
    localparam logic [30:0] X_EXADD = {AOW,        2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, ADD,  Z4};
    localparam logic [30:0] X_EXSUB = {AOW,        2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, SUB,  Z4};
    localparam logic [30:0] X_EXAND = {AOW,        2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, AND,  Z4};
    localparam logic [30:0] X_EXADI = {AOW,        2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, ADD,  Z4};
    localparam logic [30:0] X_WBR   = {RBW,        2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_WBI   = {RBW,        2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_WBHI  = {RBW,        2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, PASS, Z4};
    localparam logic [30:0] X_WBLO  = {RBW,        2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0, PASS, Z4};
    localparam logic [30:0] X_AC    = {AOW,        2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, ADD,  Z4};
    localparam logic [30:0] X_M0    = {NONE,       2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_M2    = {MDRW,       2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_LWB   = {RBW,        2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, PASS, Z4};
    localparam logic [30:0] X_SW    = {MEMW,       2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_BRT   = {PCW,        2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, SUB,  Z4};
    localparam logic [30:0] X_BRN   = {NONE,       2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, SUB,  Z4};
    localparam logic [30:0] X_J     = {PCW,        2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_JAL0  = {AOW,        2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_JAL1  = {RBW | PCW,  2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_JR    = {PCW,        2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_MS    = {MC,         2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_E0V   = {AOW,        2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, SUB,  Z4};
    localparam logic [30:0] X_E1V   = {EPCW,       2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_E2V   = {NONE,       2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_E3V   = {PCW,        2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, PASS, Z4};
    localparam logic [30:0] X_E0O   = {AOW,        2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, SUB,  Z4};
    localparam logic [30:0] X_E1O   = {EPCW,       2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, PASS, Z4};
    localparam logic [30:0] X_E2O   = {NONE,       2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, PASS, Z4};
    localparam logic [30:0] X_E3O   = {PCW,        2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, PASS, Z4};

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B,
                           OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03,
                           OP_BAD = 6'h3F;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_JR = 6'h08,
                           FN_MULT = 6'h18, FN_MFHI = 6'h10, FN_MFLO = 6'h12, FN_BAD = 6'h3F;
    // per-cycle input flags {ZERO, OVERFLOW, mult_end, reset}
    localparam logic [3:0] FL_NONE = 4'b0000, FL_Z = 4'b1000, FL_OVF = 4'b0100,
                           FL_ME = 4'b0010, FL_RST = 4'b0001;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [3:0]  fl;
        logic [30:0] e;
    } vec_t;

    function automatic vec_t c(input logic [5:0] op, input logic [5:0] fn,
                               input logic [3:0] fl, input logic [30:0] e);
        vec_t v;
        v.op = op; v.fn = fn; v.fl = fl; v.e = e;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.OPCODE   = v.op;
        bus.FUNCT    = v.fn;
        bus.ZERO     = v.fl[3];
        bus.OVERFLOW = v.fl[2];
        bus.mult_end = v.fl[1];
        reset        = v.fl[0];
    endtask

    task automatic test_reset();
        apply(c(OP_R, FN_ADD, FL_RST, X_ZERO));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (obs !== X_ZERO) begin
                bad++;
                $display("FAIL reset cyc%0d: got %h want %h", i + 1, obs, X_ZERO);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_lw();
        vec_t q[$];
        q = '{c(OP_R, FN_ADD, FL_NONE, X_ZERO), c(OP_R, FN_ADD, FL_NONE, X_ZERO),
              c(OP_R, FN_ADD, FL_NONE, X_F2),   c(OP_R, FN_ADD, FL_NONE, X_D),
              c(OP_R, FN_ADD, FL_NONE, X_EXADD), c(OP_R, FN_ADD, FL_NONE, X_WBR),
              c(OP_LW, 6'h00, FL_NONE, X_ZERO), c(OP_LW, 6'h00, FL_NONE, X_ZERO),
              c(OP_LW, 6'h00, FL_NONE, X_F2),   c(OP_LW, 6'h00, FL_NONE, X_D),
              c(OP_LW, 6'h00, FL_NONE, X_AC),   c(OP_LW, 6'h00, FL_NONE, X_M0),
              c(OP_LW, 6'h00, FL_NONE, X_ZERO), c(OP_LW, 6'h00, FL_NONE, X_M2),
              c(OP_LW, 6'h00, FL_NONE, X_LWB)};
        foreach (q[i]) begin
            if (i != 0) begin @(posedge clk); #1; end
            apply(q[i]);
            #1;
            total++;
            if (obs !== q[i].e) begin
                bad++;
                $display("FAIL add_lw cyc%0d: got %h want %h", i + 1, obs, q[i].e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_branch();
        vec_t q[$];
        q = '{c(OP_BEQ, 6'h00, FL_Z, X_ZERO),    c(OP_BEQ, 6'h00, FL_Z, X_ZERO),
              c(OP_BEQ, 6'h00, FL_Z, X_F2),      c(OP_BEQ, 6'h00, FL_Z, X_D),
              c(OP_BEQ, 6'h00, FL_Z, X_BRT),
              c(OP_BNE, 6'h00, FL_Z, X_ZERO),    c(OP_BNE, 6'h00, FL_Z, X_ZERO),
              c(OP_BNE, 6'h00, FL_Z, X_F2),      c(OP_BNE, 6'h00, FL_Z, X_D),
              c(OP_BNE, 6'h00, FL_Z, X_BRN),
              c(OP_BNE, 6'h00, FL_NONE, X_ZERO), c(OP_BNE, 6'h00, FL_NONE, X_ZERO),
              c(OP_BNE, 6'h00, FL_NONE, X_F2),   c(OP_BNE, 6'h00, FL_NONE, X_D),
              c(OP_BNE, 6'h00, FL_NONE, X_BRT),
              c(OP_BEQ, 6'h00, FL_NONE, X_ZERO), c(OP_BEQ, 6'h00, FL_NONE, X_ZERO),
              c(OP_BEQ, 6'h00, FL_NONE, X_F2),   c(OP_BEQ, 6'h00, FL_NONE, X_D),
              c(OP_BEQ, 6'h00, FL_NONE, X_BRN)};
        foreach (q[i]) begin
            if (i != 0) begin @(posedge clk); #1; end
            apply(q[i]);
            #1;
            total++;
            if (obs !== q[i].e) begin
                bad++;
                $display("FAIL branch cyc%0d: got %h want %h", i + 1, obs, q[i].e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow_invalid();
        vec_t q[$];
        q = '{c(OP_R, FN_ADD, FL_OVF, X_ZERO),  c(OP_R, FN_ADD, FL_OVF, X_ZERO),
              c(OP_R, FN_ADD, FL_OVF, X_F2),    c(OP_R, FN_ADD, FL_OVF, X_D),
              c(OP_R, FN_ADD, FL_OVF, X_EXADD), c(OP_R, FN_ADD, FL_OVF, X_E0O),
              c(OP_R, FN_ADD, FL_OVF, X_E1O),   c(OP_R, FN_ADD, FL_OVF, X_E2O),
              c(OP_R, FN_ADD, FL_OVF, X_E3O),
              c(OP_BAD, 6'h00, FL_NONE, X_ZERO), c(OP_BAD, 6'h00, FL_NONE, X_ZERO),
              c(OP_BAD, 6'h00, FL_NONE, X_F2),   c(OP_BAD, 6'h00, FL_NONE, X_D),
              c(OP_BAD, 6'h00, FL_NONE, X_E0V),  c(OP_BAD, 6'h00, FL_NONE, X_E1V),
              c(OP_BAD, 6'h00, FL_NONE, X_E2V),  c(OP_BAD, 6'h00, FL_NONE, X_E3V),
              c(OP_R, FN_BAD, FL_NONE, X_ZERO),  c(OP_R, FN_BAD, FL_NONE, X_ZERO),
              c(OP_R, FN_BAD, FL_NONE, X_F2),    c(OP_R, FN_BAD, FL_NONE, X_D),
              c(OP_R, FN_BAD, FL_NONE, X_E0V),   c(OP_R, FN_BAD, FL_NONE, X_E1V),
              c(OP_R, FN_BAD, FL_NONE, X_E2V),   c(OP_R, FN_BAD, FL_NONE, X_E3V)};
        foreach (q[i]) begin
            if (i != 0) begin @(posedge clk); #1; end
            apply(q[i]);
            #1;
            total++;
            if (obs !== q[i].e) begin
                bad++;
                $display("FAIL exception cyc%0d: got %h want %h", i + 1, obs, q[i].e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        vec_t q[$];
        q = '{c(OP_R, FN_SUB, FL_NONE, X_ZERO),   c(OP_R, FN_SUB, FL_NONE, X_ZERO),
              c(OP_R, FN_SUB, FL_NONE, X_F2),     c(OP_R, FN_SUB, FL_NONE, X_D),
              c(OP_R, FN_SUB, FL_NONE, X_EXSUB),  c(OP_R, FN_SUB, FL_NONE, X_WBR),
              c(OP_R, FN_AND, FL_OVF, X_ZERO),    c(OP_R, FN_AND, FL_OVF, X_ZERO),
              c(OP_R, FN_AND, FL_OVF, X_F2),      c(OP_R, FN_AND, FL_OVF, X_D),
              c(OP_R, FN_AND, FL_OVF, X_EXAND),   c(OP_R, FN_AND, FL_OVF, X_WBR),
              c(OP_ADDI, 6'h00, FL_NONE, X_ZERO), c(OP_ADDI, 6'h00, FL_NONE, X_ZERO),
              c(OP_ADDI, 6'h00, FL_NONE, X_F2),   c(OP_ADDI, 6'h00, FL_NONE, X_D),
              c(OP_ADDI, 6'h00, FL_NONE, X_EXADI), c(OP_ADDI, 6'h00, FL_NONE, X_WBI),
              c(OP_ADDI, 6'h00, FL_OVF, X_ZERO),  c(OP_ADDI, 6'h00, FL_OVF, X_ZERO),
              c(OP_ADDI, 6'h00, FL_OVF, X_F2),    c(OP_ADDI, 6'h00, FL_OVF, X_D),
              c(OP_ADDI, 6'h00, FL_OVF, X_EXADI), c(OP_ADDI, 6'h00, FL_OVF, X_E0O),
              c(OP_ADDI, 6'h00, FL_OVF, X_E1O),   c(OP_ADDI, 6'h00, FL_OVF, X_E2O),
              c(OP_ADDI, 6'h00, FL_OVF, X_E3O),
              c(OP_SW, 6'h00, FL_NONE, X_ZERO),   c(OP_SW, 6'h00, FL_NONE, X_ZERO),
              c(OP_SW, 6'h00, FL_NONE, X_F2),     c(OP_SW, 6'h00, FL_NONE, X_D),
              c(OP_SW, 6'h00, FL_NONE, X_AC),     c(OP_SW, 6'h00, FL_NONE, X_SW),
              c(OP_J, 6'h00, FL_NONE, X_ZERO),    c(OP_J, 6'h00, FL_NONE, X_ZERO),
              c(OP_J, 6'h00, FL_NONE, X_F2),      c(OP_J, 6'h00, FL_NONE, X_D),
              c(OP_J, 6'h00, FL_NONE, X_J),
              c(OP_JAL, 6'h00, FL_NONE, X_ZERO),  c(OP_JAL, 6'h00, FL_NONE, X_ZERO),
              c(OP_JAL, 6'h00, FL_NONE, X_F2),    c(OP_JAL, 6'h00, FL_NONE, X_D),
              c(OP_JAL, 6'h00, FL_NONE, X_JAL0),  c(OP_JAL, 6'h00, FL_NONE, X_JAL1),
              c(OP_R, FN_JR, FL_NONE, X_ZERO),    c(OP_R, FN_JR, FL_NONE, X_ZERO),
              c(OP_R, FN_JR, FL_NONE, X_F2),      c(OP_R, FN_JR, FL_NONE, X_D),
              c(OP_R, FN_JR, FL_NONE, X_JR),
              c(OP_R, FN_MFHI, FL_NONE, X_ZERO),  c(OP_R, FN_MFHI, FL_NONE, X_ZERO),
              c(OP_R, FN_MFHI, FL_NONE, X_F2),    c(OP_R, FN_MFHI, FL_NONE, X_D),
              c(OP_R, FN_MFHI, FL_NONE, X_WBHI),
              c(OP_R, FN_MFLO, FL_NONE, X_ZERO),  c(OP_R, FN_MFLO, FL_NONE, X_ZERO),
              c(OP_R, FN_MFLO, FL_NONE, X_F2),    c(OP_R, FN_MFLO, FL_NONE, X_D),
              c(OP_R, FN_MFLO, FL_NONE, X_WBLO)};
        foreach (q[i]) begin
            if (i != 0) begin @(posedge clk); #1; end
            apply(q[i]);
            #1;
            total++;
            if (obs !== q[i].e) begin
                bad++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", i + 1, obs, q[i].e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        vec_t q[$];
        q = '{c(OP_R, FN_MULT, FL_NONE, X_ZERO), c(OP_R, FN_MULT, FL_NONE, X_ZERO),
              c(OP_R, FN_MULT, FL_NONE, X_F2),   c(OP_R, FN_MULT, FL_NONE, X_D),
              c(OP_R, FN_MULT, FL_ME, X_MS)};
        for (int k = 1; k <= 32; k++)
            q.push_back(c(OP_R, FN_MULT, (k == 32) ? FL_ME : FL_NONE, X_ZERO));
        // second mult is abandoned by reset while parked, then a j runs clean
        q.push_back(c(OP_R, FN_MULT, FL_NONE, X_ZERO));
        q.push_back(c(OP_R, FN_MULT, FL_NONE, X_ZERO));
        q.push_back(c(OP_R, FN_MULT, FL_NONE, X_F2));
        q.push_back(c(OP_R, FN_MULT, FL_NONE, X_D));
        q.push_back(c(OP_R, FN_MULT, FL_NONE, X_MS));
        q.push_back(c(OP_R, FN_MULT, FL_NONE, X_ZERO));
        q.push_back(c(OP_R, FN_MULT, FL_RST, X_ZERO));
        q.push_back(c(OP_J, 6'h00, FL_NONE, X_ZERO));
        q.push_back(c(OP_J, 6'h00, FL_NONE, X_ZERO));
        q.push_back(c(OP_J, 6'h00, FL_NONE, X_ZERO));
        q.push_back(c(OP_J, 6'h00, FL_NONE, X_F2));
        q.push_back(c(OP_J, 6'h00, FL_NONE, X_D));
        q.push_back(c(OP_J, 6'h00, FL_NONE, X_J));
        foreach (q[i]) begin
            if (i != 0) begin @(posedge clk); #1; end
            apply(q[i]);
            #1;
            total++;
            if (obs !== q[i].e) begin
                bad++;
                $display("FAIL mult cyc%0d: got %h want %h", i + 1, obs, q[i].e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        vec_t q[$];
        q = '{c(OP_R, FN_ADD, FL_NONE, X_ZERO), c(OP_R, FN_ADD, FL_NONE, X_ZERO),
              c(OP_R, FN_ADD, FL_NONE, X_F2),   c(OP_R, FN_ADD, FL_NONE, X_D),
              c(OP_R, FN_ADD, FL_RST, X_EXADD), c(OP_J, 6'h00, FL_NONE, X_ZERO),
              c(OP_J, 6'h00, FL_NONE, X_ZERO),  c(OP_J, 6'h00, FL_NONE, X_ZERO),
              c(OP_J, 6'h00, FL_NONE, X_F2),    c(OP_J, 6'h00, FL_NONE, X_D),
              c(OP_J, 6'h00, FL_NONE, X_J),     c(OP_J, 6'h00, FL_NONE, X_ZERO)};
        foreach (q[i]) begin
            if (i != 0) begin @(posedge clk); #1; end
            apply(q[i]);
            #1;
            total++;
            if (obs !== q[i].e) begin
                bad++;
                $display("FAIL reset_midflight cyc%0d: got %h want %h", i + 1, obs, q[i].e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_lw();
        test_branch();
        test_overflow_invalid();
        test_back_to_back();
        test_mult();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle control unit for the processor datapath. A single FSM sequences fetch, decode, execute, memory and writeback for the supported MIPS subset, and raises the exception sequence for invalid opcodes and arithmetic overflow. It drives every write enable and mux select of the datapath. It takes only the decoded instruction fields and the ALU and multiplier status flags as inputs.

## Interface
- No parameters; encodings below are fixed.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- OPCODE  in  6  IR[31:26]
- FUNCT  in  6  IR[5:0]
- ZERO, OVERFLOW  in  1 each  ALU flags, combinational for the current ALU operands
- mult_end  in  1  multiplier done pulse
- PC_w, EPC_w, MEM_w, IR_w, ALUOut_w, RB_w, AB_w, MEM_DATA_REG_w, mult_control  out  1 each  write/start strobes
- M_PC  out  2  0 ALU result, 1 ALUOut reg, 2 jump target, 3 EPC
- M_MEM  out  2  0 PC, 1 ALUOut reg, 2 reserved, 3 exception vector
- M_ALUSrcA  out  2  0 PC, 1 A, 2 zero-extended memory byte
- M_ALUSrcB  out  2  0 B, 1 constant 4, 2 signext(imm), 3 signext(imm)<<2
- M_WREG  out  2  0 rt, 1 rd, 2 register 31
- M_WDATA  out  2  0 ALUOut reg, 1 LScontrol out, 2 hi, 3 lo
- M_EXC  out  2  0 invalid opcode (addr 253), 1 overflow (addr 254)
- ALUOp  out  4  0000 pass A, 0001 add, 0010 sub, 0011 and
- LS_control, SS_control  out  2 each  0 = word, only value used
- state_dbg  out  6  current state encoding

## Operation
- Outputs are decoded combinationally from the state register. Exception: PC_w in BR also depends on ZERO and OPCODE. Any output not listed for a state is 0.
- RESET: all outputs 0; next state F0.
- F0: M_MEM=0, memory read issued.
- F1: wait; M_MEM held at 0.
- F2: IR_w, SrcA=0, SrcB=1, add, M_PC=0, PC_w (PC<=PC+4).
- D: AB_w; SrcA=0, SrcB=3, add, ALUOut_w (branch target); dispatch on OPCODE/FUNCT.
- R add(0x20)/sub(0x22)/and(0x24):
  - EX: SrcA=1, SrcB=0, matching ALUOp, ALUOut_w.
  - Add or sub with OVERFLOW=1 in EX goes to EXC0 with M_EXC=1. Otherwise WB.
  - WB: RB_w, M_WREG=1, M_WDATA=0.
- addi(0x08): EX with SrcB=2, add; overflow rule as above; WB with M_WREG=0.
- lw(0x23):
  - AC: SrcA=1, SrcB=2, add, ALUOut_w.
  - M0: M_MEM=1. M1: wait. M2: MEM_DATA_REG_w.
  - LWB: RB_w, M_WREG=0, M_WDATA=1, LS_control=0.
- sw(0x2B): AC, then SW: M_MEM=1, MEM_w, SS_control=0.
- beq(0x04)/bne(0x05): BR: SrcA=1, SrcB=0, sub, M_PC=1; PC_w=ZERO for beq, !ZERO for bne.
- j(0x02): J: M_PC=2, PC_w.
- jal(0x03):
  - JAL0: SrcA=0, pass, ALUOut_w.
  - JAL1: RB_w, M_WREG=2, M_WDATA=0, M_PC=2, PC_w.
- jr(0x08 R): JR: SrcA=1, pass, M_PC=0, PC_w.
- mult(0x18 R): MS: mult_control=1 for exactly one cycle. MW: hold until mult_end=1.
- mfhi(0x10)/mflo(0x12): WB with M_WREG=1, M_WDATA=2/3.
- Any other OPCODE, or R-type FUNCT, goes from D to EXC0 with M_EXC=0.
- Exception sequence:
  - EXC0: SrcA=0, SrcB=1, sub, ALUOut_w (PC-4).
  - EXC1: EPC_w, M_MEM=3.
  - EXC2: wait, M_MEM=3.
  - EXC3: SrcA=2, pass, M_PC=0, PC_w.
  - The exception code is latched at entry to EXC0 and drives M_EXC through EXC3.
- Every terminal state (WB, LWB, SW, BR, J, JAL1, JR, MW on mult_end, EXC3) returns to F0.

## Timing
- Memory read latency: data valid 2 cycles after the address is driven, hence the F1/M1/EXC2 waits.
- Instruction cycle counts from F0 to the next F0:
  - R-ALU, addi, jal, sw: 6 cycles.
  - Branch, j, jr, mfhi, mflo: 5 cycles.
  - lw: 9 cycles.
  - mult: 6 + multiplier latency.
  - Exception: 4 (fetch and decode) + 4 (EXC0..EXC3), plus 1 EX cycle for overflow.
- Overflow is sampled only in EX of add/sub/addi. RB_w is never asserted for an overflowing instruction.
- mult_end arriving in the same cycle MS is active is ignored. Only MW samples mult_end.
- reset=1 in any state: the next state is RESET and all outputs are 0 on the following cycle. In-flight writes are abandoned and no partial writeback occurs.

## Test plan
- Reset held 3 cycles, then released: outputs all 0 while in RESET; F0 follows; F2 asserts IR_w and PC_w exactly once.
- add $3,$1,$2 with 5+7 → RB_w on cycle 6 with M_WREG=1. Then lw $4,0($0) → MEM_DATA_REG_w on cycle 8 and RB_w on cycle 9 with M_WDATA=1.
- beq with ZERO=1 → PC_w=1, M_PC=1 in BR. bne with ZERO=1 → PC_w=0, and next state is F0.
- add with OVERFLOW=1 in EX → no RB_w; EXC0..EXC3 with M_EXC=1; EPC_w once; PC_w with SrcA=2 in EXC3.
- OPCODE 0x3F → D goes to EXC0 with M_EXC=0, selecting vector address 253.
- mult with mult_end after 32 cycles → mult_control high 1 cycle, FSM parks in MW, returns to F0 the cycle after mult_end. Reset pulsed mid-MW → RESET with all outputs 0.
